// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite slave register bank: NUM_REGS word registers behind independent write and read FSMs.
// Optional macro AXI_SLV_WSTRB_EN: honour S_WSTRB byte lanes; otherwise every write updates the full word.
module axi4_lite_slave_regs #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_REGS      = 16
) (
    input  logic                        ACLK,
    input  logic                        ARESET,
    input  logic [ADDRESS_WIDTH-1:0]    S_AWADDR,
    input  logic                        S_AWVALID,
    output logic                        S_AWREADY,
    input  logic [DATA_WIDTH-1:0]       S_WDATA,
    input  logic [DATA_WIDTH/8-1:0]     S_WSTRB,
    input  logic                        S_WVALID,
    output logic                        S_WREADY,
    output logic [1:0]                  S_BRESP,
    output logic                        S_BVALID,
    input  logic                        S_BREADY,
    input  logic [ADDRESS_WIDTH-1:0]    S_ARADDR,
    input  logic                        S_ARVALID,
    output logic                        S_ARREADY,
    output logic [DATA_WIDTH-1:0]       S_RDATA,
    output logic [1:0]                  S_RRESP,
    output logic                        S_RVALID,
    input  logic                        S_RREADY,
    output logic                        wr_pulse,
    output logic [$clog2(NUM_REGS)-1:0] wr_index
);

    localparam int IDX_W  = $clog2(NUM_REGS);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_LIMIT = ADDRESS_WIDTH'(NUM_REGS * 4);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_WAIT_DATA, W_WAIT_ADDR, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t w_state, w_state_next;
    r_state_t r_state, r_state_next;

    logic [DATA_WIDTH-1:0]    regs [NUM_REGS];
    logic [ADDRESS_WIDTH-1:0] aw_addr_q;
    logic [DATA_WIDTH-1:0]    w_data_q;
    logic [STRB_W-1:0]        w_strb_q;

    logic                     aw_hs, w_hs, ar_hs;
    logic                     commit;
    logic [ADDRESS_WIDTH-1:0] commit_addr;
    logic [DATA_WIDTH-1:0]    commit_data;
    logic [STRB_W-1:0]        commit_strb;
    logic                     commit_in_range;
    logic [IDX_W-1:0]         commit_idx;
    logic                     rd_in_range;
    logic [IDX_W-1:0]         rd_idx;

    assign aw_hs = S_AWVALID && S_AWREADY;
    assign w_hs  = S_WVALID && S_WREADY;
    assign ar_hs = S_ARVALID && S_ARREADY;

    assign commit_in_range = commit_addr < ADDR_LIMIT;
    assign commit_idx      = commit_addr[2 +: IDX_W];
    assign rd_in_range     = S_ARADDR < ADDR_LIMIT;
    assign rd_idx          = S_ARADDR[2 +: IDX_W];

`ifndef AXI_SLV_WSTRB_EN
    logic unused_strb;
    assign unused_strb = ^commit_strb;
`endif

    // Readies are registered copies of the next-state decode so they stay low throughout reset.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_state   <= W_IDLE;
            r_state   <= R_IDLE;
            S_AWREADY <= 1'b0;
            S_WREADY  <= 1'b0;
            S_ARREADY <= 1'b0;
        end else begin
            w_state   <= w_state_next;
            r_state   <= r_state_next;
            S_AWREADY <= (w_state_next == W_IDLE) || (w_state_next == W_WAIT_ADDR);
            S_WREADY  <= (w_state_next == W_IDLE) || (w_state_next == W_WAIT_DATA);
            S_ARREADY <= (r_state_next == R_IDLE);
        end
    end

    // The commit takes whichever half arrives on this edge live and the other half from its latch.
    always_comb begin
        w_state_next = w_state;
        commit       = 1'b0;
        commit_addr  = S_AWADDR;
        commit_data  = S_WDATA;
        commit_strb  = S_WSTRB;
        case (w_state)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit       = 1'b1;
                    w_state_next = W_RESP;
                end else if (aw_hs) begin
                    w_state_next = W_WAIT_DATA;
                end else if (w_hs) begin
                    w_state_next = W_WAIT_ADDR;
                end
            end
            W_WAIT_DATA: begin
                commit_addr = aw_addr_q;
                if (w_hs) begin
                    commit       = 1'b1;
                    w_state_next = W_RESP;
                end
            end
            W_WAIT_ADDR: begin
                commit_data = w_data_q;
                commit_strb = w_strb_q;
                if (aw_hs) begin
                    commit       = 1'b1;
                    w_state_next = W_RESP;
                end
            end
            W_RESP: begin
                if (S_BREADY) w_state_next = W_IDLE;
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_state_next = R_DATA;
            R_DATA:  if (S_RREADY) r_state_next = R_IDLE;
            default: r_state_next = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            S_BVALID  <= 1'b0;
            S_BRESP   <= 2'b00;
            wr_pulse  <= 1'b0;
            wr_index  <= '0;
        end else begin
            wr_pulse <= 1'b0;
            if (aw_hs) aw_addr_q <= S_AWADDR;
            if (w_hs) begin
                w_data_q <= S_WDATA;
                w_strb_q <= S_WSTRB;
            end
            if (commit) begin
                S_BVALID <= 1'b1;
                S_BRESP  <= commit_in_range ? RESP_OKAY : RESP_SLVERR;
                if (commit_in_range) begin
                    wr_pulse <= 1'b1;
                    wr_index <= commit_idx;
`ifdef AXI_SLV_WSTRB_EN
                    for (int b = 0; b < STRB_W; b++) begin
                        if (commit_strb[b]) regs[commit_idx][8*b +: 8] <= commit_data[8*b +: 8];
                    end
`else
                    regs[commit_idx] <= commit_data;
`endif
                end
            end else if (S_BVALID && S_BREADY) begin
                S_BVALID <= 1'b0;
                S_BRESP  <= 2'b00;
            end
        end
    end

    // Read data is captured at the AR handshake, so a same-edge write is not visible yet.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            S_RVALID <= 1'b0;
            S_RDATA  <= '0;
            S_RRESP  <= 2'b00;
        end else if (ar_hs) begin
            S_RVALID <= 1'b1;
            S_RDATA  <= rd_in_range ? regs[rd_idx] : '0;
            S_RRESP  <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
        end else if (S_RVALID && S_RREADY) begin
            S_RVALID <= 1'b0;
            S_RDATA  <= '0;
            S_RRESP  <= 2'b00;
        end
    end

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Scoreboard bench for axi4_lite_slave_regs: directed writes/reads push expected B, R and wr_pulse
// results into queues; a negedge monitor pops and compares them as the DUT presents them.
module tb_axi4_lite_slave_regs;

    logic        ACLK;
    logic        ARESET;
    logic [31:0] S_AWADDR;
    logic        S_AWVALID;
    logic        S_AWREADY;
    logic [31:0] S_WDATA;
    logic [3:0]  S_WSTRB;
    logic        S_WVALID;
    logic        S_WREADY;
    logic [1:0]  S_BRESP;
    logic        S_BVALID;
    logic        S_BREADY;
    logic [31:0] S_ARADDR;
    logic        S_ARVALID;
    logic        S_ARREADY;
    logic [31:0] S_RDATA;
    logic [1:0]  S_RRESP;
    logic        S_RVALID;
    logic        S_RREADY;
    logic        wr_pulse;
    logic [3:0]  wr_index;

    int compared   = 0;
    int mismatched = 0;

    logic [1:0]  bQueue[$];
    logic [33:0] rQueue[$];
    int          pulseQueue[$];

    axi4_lite_slave_regs #(
        .ADDRESS_WIDTH(32),
        .DATA_WIDTH(32),
        .NUM_REGS(16)
    ) dut (
        .ACLK(ACLK),
        .ARESET(ARESET),
        .S_AWADDR(S_AWADDR),
        .S_AWVALID(S_AWVALID),
        .S_AWREADY(S_AWREADY),
        .S_WDATA(S_WDATA),
        .S_WSTRB(S_WSTRB),
        .S_WVALID(S_WVALID),
        .S_WREADY(S_WREADY),
        .S_BRESP(S_BRESP),
        .S_BVALID(S_BVALID),
        .S_BREADY(S_BREADY),
        .S_ARADDR(S_ARADDR),
        .S_ARVALID(S_ARVALID),
        .S_ARREADY(S_ARREADY),
        .S_RDATA(S_RDATA),
        .S_RRESP(S_RRESP),
        .S_RVALID(S_RVALID),
        .S_RREADY(S_RREADY),
        .wr_pulse(wr_pulse),
        .wr_index(wr_index)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Monitor: every presented beat or strobe is matched against the oldest expectation.
    always @(negedge ACLK) begin
        if (S_BVALID === 1'b1 && S_BREADY === 1'b1) begin
            if (bQueue.size() == 0) checkOutput("unexpected B beat", 32'(S_BRESP), 32'hFFFF_FFFF);
            else checkOutput("bresp", 32'(S_BRESP), 32'(bQueue.pop_front()));
        end
        if (S_RVALID === 1'b1 && S_RREADY === 1'b1) begin
            if (rQueue.size() == 0) begin
                checkOutput("unexpected R beat", S_RDATA, 32'hFFFF_FFFF);
            end else begin
                logic [33:0] rExp;
                rExp = rQueue.pop_front();
                checkOutput("rdata", S_RDATA, rExp[31:0]);
                checkOutput("rresp", 32'(S_RRESP), 32'(rExp[33:32]));
            end
        end
        if (wr_pulse === 1'b1) begin
            if (pulseQueue.size() == 0) checkOutput("unexpected wr_pulse", 32'(wr_index), 32'hFFFF_FFFF);
            else checkOutput("wr_index", 32'(wr_index), 32'(pulseQueue.pop_front()));
        end
    end

    // Issues one write with AW and W starting awDelay/wDelay cycles after entry; entry and exit are posedge+1.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                                 input int awDelay, input int wDelay, input logic [1:0] expResp,
                                 input bit expBeat, input bit expPulse, input int expIdx);
        bit awDone = 0;
        bit wDone  = 0;
        bit hsAw, hsW;
        int cyc = 0;
        if (expBeat) bQueue.push_back(expResp);
        if (expPulse) pulseQueue.push_back(expIdx);
        S_AWADDR = addr;
        S_WDATA  = data;
        S_WSTRB  = strb;
        while (!(awDone && wDone) && cyc < 50) begin
            S_AWVALID = !awDone && (cyc >= awDelay);
            S_WVALID  = !wDone && (cyc >= wDelay);
            @(negedge ACLK);
            hsAw = S_AWVALID && S_AWREADY;
            hsW  = S_WVALID && S_WREADY;
            if (wDone && !awDone) checkOutput("wready low while data held", 32'(S_WREADY), 32'd0);
            if (awDone && !wDone) checkOutput("awready low while addr held", 32'(S_AWREADY), 32'd0);
            @(posedge ACLK);
            #1;
            if (hsAw) awDone = 1;
            if (hsW) wDone = 1;
            cyc++;
        end
        S_AWVALID = 1'b0;
        S_WVALID  = 1'b0;
        checkOutput("write handshake completed", 32'(awDone && wDone), 32'd1);
    endtask

    task automatic applyRead(input logic [31:0] addr, input logic [31:0] expData, input logic [1:0] expResp);
        bit done = 0;
        bit hs;
        int cyc = 0;
        rQueue.push_back({expResp, expData});
        S_ARADDR  = addr;
        S_ARVALID = 1'b1;
        while (!done && cyc < 50) begin
            @(negedge ACLK);
            hs = S_ARVALID && S_ARREADY;
            @(posedge ACLK);
            #1;
            done = hs;
            cyc++;
        end
        S_ARVALID = 1'b0;
        checkOutput("read handshake completed", 32'(done), 32'd1);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge ACLK);
            #1;
        end
    endtask

    initial begin
        ARESET    = 1'b1;
        S_AWADDR  = '0;
        S_AWVALID = 1'b0;
        S_WDATA   = '0;
        S_WSTRB   = '0;
        S_WVALID  = 1'b0;
        S_BREADY  = 1'b1;
        S_ARADDR  = '0;
        S_ARVALID = 1'b0;
        S_RREADY  = 1'b1;
        idleCycles(3);

        // Reset state, then readies rise on the first edge after release.
        @(negedge ACLK);
        checkOutput("reset outputs", {25'd0, S_AWREADY, S_WREADY, S_ARREADY, S_BVALID, S_RVALID, wr_pulse, 1'b0},
                    32'd0);
        checkOutput("reset rdata", S_RDATA, 32'd0);
        @(posedge ACLK);
        #1;
        ARESET = 1'b0;
        @(negedge ACLK);
        checkOutput("readies low before first edge", {29'd0, S_AWREADY, S_WREADY, S_ARREADY}, 32'd0);
        @(posedge ACLK);
        #1;
        @(negedge ACLK);
        checkOutput("readies high after reset", {29'd0, S_AWREADY, S_WREADY, S_ARREADY}, 32'd7);
        @(posedge ACLK);
        #1;

        // AW+W together; BVALID and wr_pulse in the cycle after the handshake.
        applyStimulus(32'h08, 32'hDEADBEEF, 4'hF, 0, 0, 2'b00, 1, 1, 2);
        @(negedge ACLK);
        checkOutput("bvalid latency", 32'(S_BVALID), 32'd1);
        checkOutput("wr_pulse after commit", 32'(wr_pulse), 32'd1);
        @(posedge ACLK);
        #1;
        @(negedge ACLK);
        checkOutput("bvalid cleared / awready back", {30'd0, S_BVALID, S_AWREADY}, 32'd1);
        checkOutput("wr_pulse single cycle", 32'(wr_pulse), 32'd0);
        @(posedge ACLK);
        #1;
        applyRead(32'h08, 32'hDEADBEEF, 2'b00);
        @(negedge ACLK);
        checkOutput("rvalid latency", 32'(S_RVALID), 32'd1);
        @(posedge ACLK);
        #1;

        // W three cycles ahead of AW, then AW two cycles ahead of W.
        applyStimulus(32'h04, 32'h12345678, 4'hF, 3, 0, 2'b00, 1, 1, 1);
        applyRead(32'h04, 32'h12345678, 2'b00);
        applyStimulus(32'h0C, 32'hCAFEF00D, 4'hF, 0, 2, 2'b00, 1, 1, 3);
        applyRead(32'h0C, 32'hCAFEF00D, 2'b00);

        // Out of range: SLVERR, no pulse, nothing aliased onto reg0.
        applyStimulus(32'h40, 32'h11111111, 4'hF, 0, 0, 2'b10, 1, 0, 0);
        applyRead(32'h40, 32'h0, 2'b10);
        applyRead(32'h00, 32'h0, 2'b00);
        applyRead(32'h08, 32'hDEADBEEF, 2'b00);
        applyStimulus(32'h3C, 32'h0F0F0F0F, 4'hF, 0, 0, 2'b00, 1, 1, 15);
        applyRead(32'h3F, 32'h0F0F0F0F, 2'b00);

        // Backpressure on B for 5 cycles.
        S_BREADY = 1'b0;
        applyStimulus(32'h10, 32'h0BADCAFE, 4'hF, 0, 0, 2'b00, 1, 1, 4);
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            checkOutput("b hold {bvalid,bresp,awready,wready}", {27'd0, S_BVALID, S_BRESP, S_AWREADY, S_WREADY},
                        32'h10);
            @(posedge ACLK);
            #1;
        end
        S_BREADY = 1'b1;
        idleCycles(1);
        @(negedge ACLK);
        checkOutput("bvalid after release", 32'(S_BVALID), 32'd0);
        @(posedge ACLK);
        #1;

        // Backpressure on R for 5 cycles.
        S_RREADY = 1'b0;
        applyRead(32'h10, 32'h0BADCAFE, 2'b00);
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            checkOutput("r hold rdata", S_RDATA, 32'h0BADCAFE);
            checkOutput("r hold {rvalid,arready}", {30'd0, S_RVALID, S_ARREADY}, 32'd2);
            @(posedge ACLK);
            #1;
        end
        S_RREADY = 1'b1;
        idleCycles(1);
        @(negedge ACLK);
        checkOutput("rvalid after release", 32'(S_RVALID), 32'd0);
        checkOutput("rdata zero when idle", S_RDATA, 32'd0);
        @(posedge ACLK);
        #1;

        // Byte strobes.
        applyStimulus(32'h00, 32'hFFFFFFFF, 4'hF, 0, 0, 2'b00, 1, 1, 0);
        applyStimulus(32'h00, 32'h00000000, 4'b0101, 0, 0, 2'b00, 1, 1, 0);
`ifdef AXI_SLV_WSTRB_EN
        applyRead(32'h00, 32'hFF00FF00, 2'b00);
        applyStimulus(32'h00, 32'h12345678, 4'b0000, 0, 0, 2'b00, 1, 1, 0);
        applyRead(32'h00, 32'hFF00FF00, 2'b00);
`else
        applyRead(32'h00, 32'h00000000, 2'b00);
`endif

        // Same-edge read and write of reg3: read sees the old value.
        applyStimulus(32'h0C, 32'hAAAA0000, 4'hF, 0, 0, 2'b00, 1, 1, 3);
        idleCycles(2);
        fork
            applyStimulus(32'h0C, 32'h00005555, 4'hF, 0, 0, 2'b00, 1, 1, 3);
            applyRead(32'h0C, 32'hAAAA0000, 2'b00);
        join
        applyRead(32'h0C, 32'h00005555, 2'b00);

        // Reset while BVALID is pending aborts the beat and clears the bank.
        S_BREADY = 1'b0;
        applyStimulus(32'h0C, 32'h12121212, 4'hF, 0, 0, 2'b00, 0, 1, 3);
        ARESET = 1'b1;
        @(negedge ACLK);
        checkOutput("bvalid pending before reset edge", 32'(S_BVALID), 32'd1);
        @(posedge ACLK);
        #1;
        @(negedge ACLK);
        checkOutput("bvalid aborted by reset", 32'(S_BVALID), 32'd0);
        @(posedge ACLK);
        #1;
        ARESET   = 1'b0;
        S_BREADY = 1'b1;
        applyRead(32'h0C, 32'h0, 2'b00);
        applyRead(32'h08, 32'h0, 2'b00);

        idleCycles(5);
        checkOutput("B queue drained", 32'(bQueue.size()), 32'd0);
        checkOutput("R queue drained", 32'(rQueue.size()), 32'd0);
        checkOutput("wr_pulse queue drained", 32'(pulseQueue.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
